// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle add/sub walking one SLICE-bit
// carry-lookahead slice across the operands, LSB slice first.
module cla_seq_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             P,
  output logic             G
);

  localparam int K  = WIDTH / SLICE;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic             carry;
  logic             last;
  int               idx;

  logic [SLICE-1:0] sp;
  logic [SLICE-1:0] sg;
  logic [SLICE-1:0] sc;
  logic [SLICE-1:0] cv;
  logic [SLICE-1:0] ss;
  logic             pg;
  logic             gg;

  assign last        = (k == KW'(K - 1));
  assign idx         = int'(k) * SLICE;
  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);

  // One lookahead slice: carries, sum bits and slice P/G terms.
  always_comb begin
    logic cr;
    logic gr;
    sp = a_q[idx +: SLICE] ^ b_q[idx +: SLICE];
    sg = a_q[idx +: SLICE] & b_q[idx +: SLICE];
    sc = '0;
    cv = '0;
    cr = carry;
    gr = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      cv[i] = cr;
      sc[i] = sg[i] | (sp[i] & cr);
      cr    = sc[i];
      gr    = sg[i] | (sp[i] & gr);
    end
    ss = sp ^ cv;
    pg = &sp;
    gg = gr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept in IDLE, K slices in RUN, handshake in DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN:     if (last)        state_nx = DONE;
      DONE:    if (res_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, slice walk, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      k     <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
      P     <= 1'b0;
      G     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : c_in;
            k     <= '0;
            sum   <= '0;
            P     <= 1'b1;
            G     <= 1'b0;
          end
        end
        RUN: begin
          sum[idx +: SLICE] <= ss;
          carry <= sc[SLICE-1];
          P     <= P & pg;
          G     <= gg | (pg & G);
          if (last) begin
            c_out <= sc[SLICE-1];
            ovf   <= cv[SLICE-1] ^ sc[SLICE-1];
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule
